// File: rtl/oc8051_cxrom_prefetch_if.sv
// Fetch-port and code-ROM bus of the oc8051 prefetch buffer.
// master: core/ROM side, slave: prefetch buffer.
interface oc8051_cxrom_prefetch_if;
  logic [15:0] cpu_addr;
  logic        cpu_stb;
  logic        cpu_ack;
  logic [31:0] cpu_data;
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_in;

  modport master (
    output cpu_addr, cpu_stb, cxrom_data_in,
    input  cpu_ack, cpu_data, cxrom_addr
  );

  modport slave (
    input  cpu_addr, cpu_stb, cxrom_data_in,
    output cpu_ack, cpu_data, cxrom_addr
  );
endinterface

// File: rtl/oc8051_cxrom_prefetch.sv
// Sequential prefetch queue between the oc8051 fetch port and oc8051_cxrom.
// Optional hit/miss statistics: define OC8051_PREFETCH_STATS_EN.
module oc8051_cxrom_prefetch #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  oc8051_cxrom_prefetch_if.slave        bus,
  output logic [15:0]                   hit_cnt,
  output logic [15:0]                   miss_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [CW-1:0] count;
  logic [15:0]   head_addr;
  logic [15:0]   fetch_addr;
  logic          pend;

  logic          accept, hit, miss, push;
  logic [15:0]   d, lim;
  logic [CW-1:0] k;
  logic [PW-1:0] k_ptr, w0_ptr, w1_ptr, tail_ptr;
  logic [31:0]   w0, w1, hit_data;

  always_comb begin
    accept   = bus.cpu_stb && !bus.cpu_ack;
    d        = bus.cpu_addr - head_addr;
    lim      = 16'({count, 2'b00}) - 16'd4;
    hit      = accept && (count != '0) && (d <= lim);
    // After a miss the held request only waits for the restarted stream;
    // it must not flush again or be counted as another miss.
    miss     = accept && !hit && !pend;
    push     = (state == STREAM) && (count < CW'(DEPTH)) && !miss;
    k        = d[CW+1:2];
    k_ptr    = d[PW+1:2];
    w0_ptr   = head_ptr + k_ptr;
    w1_ptr   = w0_ptr + PW'(1);
    tail_ptr = head_ptr + count[PW-1:0];
    w0       = mem[w0_ptr];
    w1       = mem[w1_ptr];
    case (d[1:0])
      2'd0:    hit_data = w0;
      2'd1:    hit_data = {w1[7:0],  w0[31:8]};
      2'd2:    hit_data = {w1[15:0], w0[31:16]};
      default: hit_data = {w1[23:0], w0[31:24]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= bus.cxrom_data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      head_ptr     <= '0;
      head_addr    <= '0;
      fetch_addr   <= '0;
      pend         <= 1'b0;
      bus.cpu_ack  <= 1'b0;
      bus.cpu_data <= '0;
    end else begin
      bus.cpu_ack <= hit;
      if (hit) bus.cpu_data <= hit_data;
      if (miss) begin
        state      <= STREAM;
        count      <= '0;
        head_ptr   <= '0;
        head_addr  <= bus.cpu_addr;
        fetch_addr <= bus.cpu_addr;
        pend       <= 1'b1;
      end else begin
        if (push) fetch_addr <= fetch_addr + 16'd4;
        if (hit) begin
          pend      <= 1'b0;
          head_ptr  <= head_ptr + k_ptr;
          head_addr <= head_addr + {d[15:2], 2'b00};
        end
        count <= count - (hit ? k : '0) + {{(CW-1){1'b0}}, push};
      end
    end
  end

  assign bus.cxrom_addr = fetch_addr;

`ifdef OC8051_PREFETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit  && hit_cnt  != '1) hit_cnt  <= hit_cnt  + 16'd1;
      if (miss && miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_oc8051_cxrom_prefetch.sv
// Directed bench for oc8051_cxrom_prefetch with a combinational ROM model.
module tb_oc8051_cxrom_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hit_cnt, miss_cnt;
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  oc8051_cxrom_prefetch_if bus ();

  oc8051_cxrom_prefetch #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  // ROM contents: byte(a) = a[7:0] ^ a[15:8] ^ 0x3C
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return {rom_byte(a + 16'd3), rom_byte(a + 16'd2), rom_byte(a + 16'd1), rom_byte(a)};
  endfunction

  assign bus.cxrom_data_in = rom_word(bus.cxrom_addr);

  function automatic logic [15:0] stat_exp(input logic [15:0] n);
`ifdef OC8051_PREFETCH_STATS_EN
    return n;
`else
    return (n == 16'hFFFF) ? 16'd0 : 16'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // one idle cycle, then hold cpu_stb until ack (bounded); lat 0 = timeout
  task automatic do_req(input logic [15:0] a, output int unsigned lat,
                        output logic [31:0] data, output logic [15:0] cx0);
    @(negedge clk);
    @(negedge clk);
    bus.cpu_addr = a;
    bus.cpu_stb  = 1'b1;
    lat  = 0;
    data = '0;
    cx0  = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) cx0 = bus.cxrom_addr;
      if (bus.cpu_ack) begin
        lat  = n;
        data = bus.cpu_data;
        break;
      end
    end
    bus.cpu_stb = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int unsigned lat;
    int unsigned pre_idle;
  } vec_t;

  vec_t        vecs [8];
  int unsigned lat;
  logic [31:0] data;
  logic [15:0] cx0;

  initial begin
    vecs[0] = '{16'h0000, 32'h3F3E3D3C, 3, 0};
    vecs[1] = '{16'h0004, 32'h3B3A3938, 1, 0};
    vecs[2] = '{16'h0008, 32'h37363534, 1, 0};
    vecs[3] = '{16'h0100, 32'h3E3F3C3D, 3, 0};
    vecs[4] = '{16'h0106, 32'h34353A3B, 1, 3};
    vecs[5] = '{16'h0200, 32'h3D3C3F3E, 3, 0};
    vecs[6] = '{16'hFFFC, 32'h3C3D3E3F, 3, 0};
    vecs[7] = '{16'h0002, 32'h39383F3E, 1, 0};

    bus.cpu_stb  = 1'b0;
    bus.cpu_addr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",   32'(bus.cpu_ack),    32'd0);
    chk("rst_data",  bus.cpu_data,        32'd0);
    chk("rst_cxaddr", 32'(bus.cxrom_addr), 32'd0);
    chk("rst_hits",  32'(hit_cnt),        32'd0);
    chk("rst_miss",  32'(miss_cnt),       32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < 8; i++) begin
      repeat (vecs[i].pre_idle) @(posedge clk);
      do_req(vecs[i].addr, lat, data, cx0);
      chk($sformatf("lat_%h", vecs[i].addr), lat, vecs[i].lat);
      chk($sformatf("data_%h", vecs[i].addr), data, vecs[i].data);
      if (vecs[i].lat == 3)
        chk($sformatf("miss_cx_%h", vecs[i].addr), 32'(cx0), 32'(vecs[i].addr));
      if (i == 0) begin
        chk("first_miss_cnt", 32'(miss_cnt), 32'(stat_exp(16'd1)));
      end
      if (i == 2) begin
        // queue fills to 4 words, then the ROM address holds
        repeat (4) @(posedge clk);
        #1;
        chk("full_cx_a", 32'(bus.cxrom_addr), 32'h0018);
        repeat (2) @(posedge clk);
        #1;
        chk("full_cx_b", 32'(bus.cxrom_addr), 32'h0018);
      end
      if (i == 4) begin
        chk("pop_cx_hold", 32'(bus.cxrom_addr), 32'h0110);
        @(posedge clk);
        #1;
        chk("pop_cx_refill", 32'(bus.cxrom_addr), 32'h0114);
      end
    end
    chk("tot_hits", 32'(hit_cnt),  32'(stat_exp(16'd8)));
    chk("tot_miss", 32'(miss_cnt), 32'(stat_exp(16'd4)));

    // reset one cycle before the ack of a missed request
    @(negedge clk);
    bus.cpu_addr = 16'h0300;
    bus.cpu_stb  = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_cx", 32'(bus.cxrom_addr), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_drop_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rst_hold_cx",  32'(bus.cxrom_addr), 32'd0);
    bus.cpu_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_req(16'h0004, lat, data, cx0);
    chk("post_rst_lat",  lat, 32'd3);
    chk("post_rst_data", data, 32'h3B3A3938);
    chk("post_rst_cx",   32'(cx0), 32'h0004);
    chk("post_rst_hits", 32'(hit_cnt),  32'(stat_exp(16'd1)));
    chk("post_rst_miss", 32'(miss_cnt), 32'(stat_exp(16'd1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/oc8051_cxrom_prefetch.md
# oc8051_cxrom_prefetch

Sequential prefetch buffer between the oc8051 instruction-fetch port and the fully-combinational code ROM (`oc8051_cxrom`). It drives the ROM address and captures one 32-bit ROM word per cycle into a small queue. It serves the core's 4-byte fetch requests from that queue, assembling unaligned requests across word boundaries. On a miss it flushes the queue and restarts the stream at the requested address.

## Interface
- `DEPTH`, 4 — queue depth in 32-bit words; legal values 2, 4, 8.
- `clk`  in  1  — system clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `cpu_addr`  in  16  — byte address of the requested 4-byte fetch.
- `cpu_stb`  in  1  — fetch request; held high until `cpu_ack`.
- `cpu_ack`  out  1  — registered one-cycle acknowledge.
- `cpu_data`  out  32  — fetched bytes; valid while `cpu_ack`=1.
- `cxrom_addr`  out  16  — registered ROM byte address (`fetch_addr`).
- `cxrom_data_in`  in  32  — ROM word for `cxrom_addr`, combinational in the same cycle.
- `hit_cnt`  out  16  — saturating hit count (see Configuration).
- `miss_cnt`  out  16  — saturating miss count (see Configuration).

## Operation
- Byte order, ROM and core alike: bits [7:0] hold the byte at the address, [15:8] addr+1, [23:16] addr+2, [31:24] addr+3.
- The queue holds `count` words (0..DEPTH). Word i holds the ROM data for `head_addr + 4*i`. All address arithmetic is mod 2^16.
- State machine:
  - IDLE: after reset; no ROM fetching; `count`=0. Any request is a miss.
  - STREAM: fetching enabled.
- Fill, STREAM only: if `count` < DEPTH (value before this cycle's pop), capture `cxrom_data_in` at the tail, `fetch_addr` += 4, `count` += 1. Otherwise hold `fetch_addr`.
- Accept condition: `cpu_stb`=1 and `cpu_ack`=0. A request is never accepted in its own ack cycle.
- On accept, compute d = (`cpu_addr` − `head_addr`) mod 2^16.
- Hit: `count` ≥ 1 and d ≤ 4*`count` − 4.
  - Next cycle: `cpu_ack`=1 and `cpu_data` = queue bytes d..d+3.
  - Pop k = d>>2 words; `head_addr` += 4k.
  - Same-cycle push and pop: `count` ← `count` − k + push.
- Miss: any accepted request that is not a hit.
  - Set `count`=0, `head_addr` = `fetch_addr` = `cpu_addr`, enter STREAM.
  - Any push in that cycle is discarded. No ack in the next cycle.
  - The still-held `cpu_stb` is re-evaluated each subsequent cycle.
- The core must not change `cpu_addr` while `cpu_stb` is high and unacknowledged.

## Timing
- Values under reset, applied immediately:
  - outputs: `cpu_ack`=0, `cpu_data`=0, `cxrom_addr`=0x0000, `hit_cnt`=`miss_cnt`=0.
  - internal: state IDLE, `count`=0, `head_addr`=0.
- Hit latency: `cpu_stb` sampled at edge T, `cpu_ack` high during T+1 only.
- Miss latency: miss at T; ROM read of `cpu_addr` during T+1 (written at end of T+1); hit at T+2; `cpu_ack` at T+3.
- Peak throughput: one ack every 2 cycles.
- Full queue: `cxrom_addr` is stable and no push occurs until a pop frees space.
- Wrap-around: `fetch_addr` 0xFFFC → 0x0000 continues streaming with no special case.
- Reset asserted mid-fill or mid-ack: all state clears asynchronously; a pending ack is dropped.

## Configuration
- `OC8051_PREFETCH_STATS_EN` defined:
  - `hit_cnt` increments on each hit and saturates at 0xFFFF.
  - `miss_cnt` increments on each miss and saturates at 0xFFFF.
  - Neither counter counts the re-evaluation cycles of a held request after its miss.
- Not defined: `hit_cnt` and `miss_cnt` are constant 0 and no counter flops exist.

## Test plan
- Reset, then `cpu_stb`=1 at 0x0000 → `cxrom_addr`=0x0000 at T+1, `cpu_ack` at T+3 with the ROM word at 0x0000, `miss_cnt`=1 (stats build).
- After that miss, request 0x0004, then 0x0008 → each ack arrives 1 cycle after acceptance with the correct word. `cxrom_addr` advances by 4 per cycle until 4 words are queued, then holds.
- Head at 0x0100 with 4 words queued, request 0x0106 → `cpu_data` = {byte 0x109, 0x108, 0x107, 0x106}, `head_addr` becomes 0x0104, refill resumes next cycle.
- Streaming near 0x0100, request 0x0200 → flush, `cxrom_addr`=0x0200 next cycle, ack 3 cycles after the miss, no stale data returned.
- Request 0xFFFC, then 0x0002 → the second request hits, returning bytes 0x0002..0x0005 from the wrapped stream.
- Assert `rst` one cycle before an expected ack → `cpu_ack` stays 0, `cxrom_addr`=0; the next request is a miss.
